// File: rtl/memd_resp_pkg.sv
// Shared types and constants for the memd_resp latency-programmable data-memory responder.
package memd_resp_pkg;

  // Default datapath sizes (core register width and data-memory word-address width).
  localparam int unsigned MEMD_REG_LEN  = 32;
  localparam int unsigned MEMD_SIZE_LOG = 6;

  // Width of the access-latency down-counter; bounds LATENCY to 1..15.
  localparam int unsigned MEMD_CNT_W = 4;

  // Request direction encodings on req_rdwt / resp_rdwt.
  localparam logic MEMD_RD = 1'b0;
  localparam logic MEMD_WT = 1'b1;

  // Responder FSM states.
  typedef enum logic [1:0] {
    MEMD_RESP_IDLE = 2'd0,
    MEMD_RESP_WAIT = 2'd1,
    MEMD_RESP_RESP = 2'd2
  } memd_resp_state_e;

endpackage

// File: rtl/memd_resp_if.sv
// Request/response handshake bundle between a core (master) and the memd_resp responder (slave).
interface memd_resp_if
  import memd_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = MEMD_SIZE_LOG,
  parameter int unsigned DATA_W = MEMD_REG_LEN
);

  logic              req_valid;
  logic              req_ready;
  logic              req_rdwt;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_rdwt;
  logic [DATA_W-1:0] resp_data;

  modport master (
    output req_valid, req_rdwt, req_addr, req_data, resp_ready,
    input  req_ready, resp_valid, resp_rdwt, resp_data
  );

  modport slave (
    input  req_valid, req_rdwt, req_addr, req_data, resp_ready,
    output req_ready, resp_valid, resp_rdwt, resp_data
  );

endinterface

// File: rtl/memd_resp_array.sv
// Word-addressed storage for memd_resp: synchronous whole-array clear, one write port,
// one asynchronous read port so a read resolves in the same cycle it is addressed.
module memd_resp_array
  import memd_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = MEMD_SIZE_LOG,
  parameter int unsigned DATA_W = MEMD_REG_LEN
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage update: clear wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[ADDR_W'(i)] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port, combinational from the addressed word.
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/memd_resp.sv
// Data-memory responder: accepts one request at a time, performs the array access
// exactly LATENCY cycles after acceptance and holds the response until consumed.
module memd_resp
  import memd_resp_pkg::*;
#(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned ADDR_W  = MEMD_SIZE_LOG,
  parameter int unsigned DATA_W  = MEMD_REG_LEN
) (
  input logic        clk,
  input logic        rst,
  memd_resp_if.slave bus
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("memd_resp: LATENCY=%0d is outside the supported range 1..15", LATENCY);
  end

  localparam logic [MEMD_CNT_W-1:0] CNT_LOAD = MEMD_CNT_W'(LATENCY - 1);
  localparam logic [MEMD_CNT_W-1:0] CNT_ONE  = MEMD_CNT_W'(1);

  memd_resp_state_e state_q, state_d;
  logic [MEMD_CNT_W-1:0] cnt_q, cnt_d;
  logic                  rdwt_q, rdwt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  resp_rdwt_q, resp_rdwt_d;
  logic [DATA_W-1:0]     resp_data_q, resp_data_d;

  logic                  acc_en;
  logic                  acc_rdwt;
  logic [ADDR_W-1:0]     acc_addr;
  logic [DATA_W-1:0]     acc_data;
  logic [DATA_W-1:0]     rd_data;
  logic                  arr_we;

  // Access operands: with LATENCY=1 the access happens on the accept edge itself,
  // so the live request fields are used in IDLE; otherwise the captured copies.
  always_comb begin
    if (state_q == MEMD_RESP_IDLE) begin
      acc_rdwt = bus.req_rdwt;
      acc_addr = bus.req_addr;
      acc_data = bus.req_data;
    end else begin
      acc_rdwt = rdwt_q;
      acc_addr = addr_q;
      acc_data = data_q;
    end
    arr_we = acc_en && (acc_rdwt == MEMD_WT);
  end

  memd_resp_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .clr   (rst),
    .we    (arr_we),
    .waddr (acc_addr),
    .wdata (acc_data),
    .raddr (acc_addr),
    .rdata (rd_data)
  );

  // Next-state, latency counter, request capture and response capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdwt_d      = rdwt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    resp_rdwt_d = resp_rdwt_q;
    resp_data_d = resp_data_q;
    acc_en      = 1'b0;

    unique case (state_q)
      MEMD_RESP_IDLE: begin
        if (bus.req_valid) begin
          rdwt_d = bus.req_rdwt;
          addr_d = bus.req_addr;
          data_d = bus.req_data;
          cnt_d  = CNT_LOAD;
          if (LATENCY == 1) begin
            acc_en  = 1'b1;
            state_d = MEMD_RESP_RESP;
          end else begin
            state_d = MEMD_RESP_WAIT;
          end
        end
      end
      MEMD_RESP_WAIT: begin
        // The access fires on the edge where the counter reaches 0, which
        // places resp_valid exactly LATENCY cycles after the accept edge.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_ONE) begin
          acc_en  = 1'b1;
          state_d = MEMD_RESP_RESP;
        end
      end
      MEMD_RESP_RESP: begin
        if (bus.resp_ready) begin
          state_d = MEMD_RESP_IDLE;
        end
      end
      default: begin
        state_d = MEMD_RESP_IDLE;
      end
    endcase

    if (acc_en) begin
      resp_rdwt_d = acc_rdwt;
      resp_data_d = (acc_rdwt == MEMD_WT) ? '0 : rd_data;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MEMD_RESP_IDLE;
      cnt_q       <= '0;
      rdwt_q      <= MEMD_RD;
      addr_q      <= '0;
      data_q      <= '0;
      resp_rdwt_q <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdwt_q      <= rdwt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      resp_rdwt_q <= resp_rdwt_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign bus.req_ready  = (state_q == MEMD_RESP_IDLE);
  assign bus.resp_valid = (state_q == MEMD_RESP_RESP);
  assign bus.resp_rdwt  = resp_rdwt_q;
  assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_memd_resp.sv
// Self-checking bench for memd_resp: a LATENCY=3 instance driven by a vector table,
// directed corner sequences and random traffic, plus a LATENCY=1 instance.
module tb_memd_resp;
  import memd_resp_pkg::*;

  localparam int unsigned AW    = MEMD_SIZE_LOG;
  localparam int unsigned DW    = MEMD_REG_LEN;
  localparam int unsigned DEPTH = 2 ** AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memd_resp_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();
  memd_resp_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  memd_resp #(.LATENCY(3), .ADDR_W(AW), .DATA_W(DW)) u_dut3 (
    .clk (clk), .rst (rst), .bus (bus3)
  );
  memd_resp #(.LATENCY(1), .ADDR_W(AW), .DATA_W(DW)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  int checks = 0;
  int errors = 0;

  // Reference memory contents as seen by completed transactions.
  logic [DW-1:0] model3 [DEPTH];
  logic [DW-1:0] model1 [DEPTH];

  typedef struct {
    logic          rdwt;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            stall;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) begin
      model3[i] = '0;
      model1[i] = '0;
    end
  endtask

  // One complete transaction on the LATENCY=3 instance, stalling the response `stall` cycles.
  task automatic txn3(input logic rdwt, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input int stall, input logic [DW-1:0] exp);
    int lat;
    bit busy_bad;
    chk("t3_ready_idle", 64'(bus3.req_ready), 64'(1));
    bus3.req_valid  = 1'b1;
    bus3.req_rdwt   = rdwt;
    bus3.req_addr   = addr;
    bus3.req_data   = data;
    bus3.resp_ready = (stall == 0);
    step();
    bus3.req_valid = 1'b0;
    bus3.req_rdwt  = 1'($urandom);
    bus3.req_addr  = AW'($urandom);
    bus3.req_data  = DW'($urandom);
    lat = 1;
    busy_bad = 1'b0;
    while (!bus3.resp_valid && lat < 20) begin
      if (bus3.req_ready) busy_bad = 1'b1;
      step();
      lat++;
    end
    chk("t3_latency", 64'(lat), 64'(3));
    chk("t3_ready_busy", 64'(busy_bad), 64'(0));
    chk("t3_resp_rdwt", 64'(bus3.resp_rdwt), 64'(rdwt));
    chk("t3_resp_data", 64'(bus3.resp_data), 64'(exp));
    chk("t3_ready_resp", 64'(bus3.req_ready), 64'(0));
    for (int i = 0; i < stall; i++) begin
      step();
      chk("t3_stall_valid", 64'(bus3.resp_valid), 64'(1));
      chk("t3_stall_data", 64'(bus3.resp_data), 64'(exp));
      chk("t3_stall_ready", 64'(bus3.req_ready), 64'(0));
    end
    bus3.resp_ready = 1'b1;
    step();
    chk("t3_done_valid", 64'(bus3.resp_valid), 64'(0));
    chk("t3_done_ready", 64'(bus3.req_ready), 64'(1));
    bus3.resp_ready = 1'b0;
    if (rdwt) model3[addr] = data;
  endtask

  // One transaction on the LATENCY=1 instance with resp_ready held high.
  task automatic txn1(input logic rdwt, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input logic [DW-1:0] exp);
    chk("t1_ready_idle", 64'(bus1.req_ready), 64'(1));
    bus1.req_valid  = 1'b1;
    bus1.req_rdwt   = rdwt;
    bus1.req_addr   = addr;
    bus1.req_data   = data;
    bus1.resp_ready = 1'b1;
    step();
    bus1.req_valid = 1'b0;
    chk("t1_valid", 64'(bus1.resp_valid), 64'(1));
    chk("t1_rdwt", 64'(bus1.resp_rdwt), 64'(rdwt));
    chk("t1_data", 64'(bus1.resp_data), 64'(exp));
    step();
    chk("t1_done_valid", 64'(bus1.resp_valid), 64'(0));
    chk("t1_done_ready", 64'(bus1.req_ready), 64'(1));
    bus1.resp_ready = 1'b0;
    if (rdwt) model1[addr] = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat;
    int accepts;
    int last_acc;
    bit busy_bad;
    bit seen;
    bit acc;
    bit prev_acc;
    logic          r_rdwt;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;

    vecs[0] = '{rdwt: MEMD_WT, addr: 5,  data: 32'hDEADBEEF, stall: 0, exp: 32'h0};
    vecs[1] = '{rdwt: MEMD_RD, addr: 5,  data: 32'h0,        stall: 0, exp: 32'hDEADBEEF};
    vecs[2] = '{rdwt: MEMD_RD, addr: 6,  data: 32'h0,        stall: 0, exp: 32'h0};
    vecs[3] = '{rdwt: MEMD_RD, addr: 5,  data: 32'h0,        stall: 4, exp: 32'hDEADBEEF};
    vecs[4] = '{rdwt: MEMD_WT, addr: 63, data: 32'hFFFFFFFF, stall: 2, exp: 32'h0};
    vecs[5] = '{rdwt: MEMD_RD, addr: 63, data: 32'h0,        stall: 1, exp: 32'hFFFFFFFF};
    vecs[6] = '{rdwt: MEMD_RD, addr: 0,  data: 32'h0,        stall: 0, exp: 32'h0};
    vecs[7] = '{rdwt: MEMD_WT, addr: 5,  data: 32'h0BADF00D, stall: 0, exp: 32'h0};

    model_clear();
    rst = 1'b1;
    bus3.req_valid = 1'b0; bus3.req_rdwt = 1'b0; bus3.req_addr = '0; bus3.req_data = '0;
    bus3.resp_ready = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_rdwt = 1'b0; bus1.req_addr = '0; bus1.req_data = '0;
    bus1.resp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    chk("rst3_req_ready", 64'(bus3.req_ready), 64'(1));
    chk("rst3_resp_valid", 64'(bus3.resp_valid), 64'(0));
    chk("rst3_resp_rdwt", 64'(bus3.resp_rdwt), 64'(0));
    chk("rst3_resp_data", 64'(bus3.resp_data), 64'(0));
    chk("rst1_req_ready", 64'(bus1.req_ready), 64'(1));
    chk("rst1_resp_valid", 64'(bus1.resp_valid), 64'(0));

    for (int v = 0; v < 8; v++) begin
      txn3(vecs[v].rdwt, vecs[v].addr, vecs[v].data, vecs[v].stall, vecs[v].exp);
    end

    // Request while busy: a write to 7 is held during the WAIT of a read and must be ignored.
    bus3.req_valid = 1'b1; bus3.req_rdwt = MEMD_RD; bus3.req_addr = 7; bus3.resp_ready = 1'b1;
    step();
    bus3.req_rdwt = MEMD_WT; bus3.req_data = 32'hA5A5A5A5;
    lat = 1;
    busy_bad = 1'b0;
    while (!bus3.resp_valid && lat < 20) begin
      if (bus3.req_ready) busy_bad = 1'b1;
      step();
      lat++;
    end
    bus3.req_valid = 1'b0;
    chk("busy_latency", 64'(lat), 64'(3));
    chk("busy_ready_low", 64'(busy_bad), 64'(0));
    chk("busy_resp_rdwt", 64'(bus3.resp_rdwt), 64'(MEMD_RD));
    chk("busy_resp_data", 64'(bus3.resp_data), 64'(0));
    step();
    chk("busy_done_valid", 64'(bus3.resp_valid), 64'(0));
    bus3.resp_ready = 1'b0;
    txn3(MEMD_RD, 7, 32'h0, 0, 32'h0);
    txn3(MEMD_WT, 7, 32'hA5A5A5A5, 0, 32'h0);
    txn3(MEMD_RD, 7, 32'h0, 0, 32'hA5A5A5A5);

    // Reset one cycle after accepting a write: the write is lost and the array cleared.
    bus3.req_valid = 1'b1; bus3.req_rdwt = MEMD_WT; bus3.req_addr = 9; bus3.req_data = 32'h1234;
    step();
    bus3.req_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
    chk("rstw_req_ready", 64'(bus3.req_ready), 64'(1));
    chk("rstw_resp_valid", 64'(bus3.resp_valid), 64'(0));
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus3.resp_valid) seen = 1'b1;
    end
    chk("rstw_no_resp", 64'(seen), 64'(0));
    txn3(MEMD_RD, 9, 32'h0, 0, 32'h0);
    txn3(MEMD_RD, 7, 32'h0, 0, 32'h0);

    // Random traffic against the reference memory.
    for (int n = 0; n < 40; n++) begin
      r_rdwt = 1'($urandom_range(0, 1));
      r_addr = AW'($urandom_range(0, 15));
      r_data = DW'($urandom);
      txn3(r_rdwt, r_addr, r_data, int'($urandom_range(0, 3)), r_rdwt ? '0 : model3[r_addr]);
    end

    // LATENCY=1: back-to-back reads of address 0 with the request held.
    bus1.req_valid = 1'b1; bus1.req_rdwt = MEMD_RD; bus1.req_addr = 0; bus1.resp_ready = 1'b1;
    accepts = 0;
    last_acc = -1;
    prev_acc = 1'b0;
    for (int c = 0; c < 12; c++) begin
      acc = bus1.req_valid && bus1.req_ready;
      if (acc) begin
        if (last_acc >= 0) chk("l1_accept_gap", 64'(c - last_acc), 64'(2));
        last_acc = c;
        accepts++;
      end
      step();
      if (acc) begin
        chk("l1_valid_next", 64'(bus1.resp_valid), 64'(1));
        chk("l1_data", 64'(bus1.resp_data), 64'(model1[0]));
      end
      prev_acc = acc;
    end
    bus1.req_valid = 1'b0;
    bus1.resp_ready = 1'b0;
    chk("l1_accepts", 64'(accepts), 64'(6));
    chk("l1_last_idle", 64'(prev_acc), 64'(0));
    txn1(MEMD_WT, 0, 32'h55AA_1234, 32'h0);
    txn1(MEMD_RD, 0, 32'h0, 32'h55AA_1234);
    for (int n = 0; n < 10; n++) begin
      r_rdwt = 1'($urandom_range(0, 1));
      r_addr = AW'($urandom_range(0, 3));
      r_data = DW'($urandom);
      txn1(r_rdwt, r_addr, r_data, r_rdwt ? '0 : model1[r_addr]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
